fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 36 +++
 rtl/fetch_queue_if.sv | 46 ++++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_queue.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module   : fetch_queue_pkg
// Brief    : Shared types and constants for the instruction fetch queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int unsigned INST_BYTES  = 4;
    localparam int unsigned FETCH_BYTES = 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
`ifdef FETCHQ_ILLEGAL_CHECK_EN
        logic        illegal;
`endif
    } fetch_entry_t;

`ifdef FETCHQ_ILLEGAL_CHECK_EN
    // Only 32-bit encodings (low bits 2'b11) are accepted; all-zero is reserved.
    function automatic logic is_illegal(input logic [31:0] inst);
        return (inst[1:0] != 2'b11) || (inst == 32'd0);
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Memory request/response, decoder and redirect signals of the
//            fetch queue. Config: FETCHQ_ILLEGAL_CHECK_EN adds out_illegal.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_queue_if;

    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef FETCHQ_ILLEGAL_CHECK_EN
    logic        out_illegal;

    modport master (
        output req_valid, req_addr, out_valid, out_inst, out_pc, out_illegal,
        input  req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  req_valid, req_addr, out_valid, out_inst, out_pc, out_illegal,
        output req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
    );
`else
    modport master (
        output req_valid, req_addr, out_valid, out_inst, out_pc,
        input  req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  req_valid, req_addr, out_valid, out_inst, out_pc,
        output req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
    );
`endif

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Entry FIFO with two write ports (in order) and one read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push0,
    input  fetch_entry_t             i_push0_data,
    input  logic                     i_push1,
    input  fetch_entry_t             i_push1_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [1:0]         w_n_push;

    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    // Port 1 only ever carries the second half of a response, so it needs port 0.
    assign w_n_push  = {1'b0, i_push0} + {1'b0, i_push0 && i_push1};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push0) begin
                r_mem[r_wr_ptr] <= i_push0_data;
            end
            if (i_push0 && i_push1) begin
                r_mem[w_wr_ptr1] <= i_push1_data;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W+1)'(w_n_push) - (PTR_W+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction fetch queue: issues 8-byte fetches, splits responses
//            into 32-bit entries, handles redirects by dropping stale data.
//            Config: FETCHQ_ILLEGAL_CHECK_EN adds a per-entry illegal flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          entry_pc,
    fetch_queue_if.master        bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [63:0]        r_fetch_pc;
    logic [63:0]        r_resp_pc;
    logic               r_skip_lo;
    logic [OUT_W-1:0]   r_outst;
    logic [OUT_W-1:0]   r_drop;
    logic [OUT_W-1:0]   w_drop_next;
    logic [CNT_W-1:0]   w_count;
    logic [31:0]        w_free;
    logic [31:0]        w_need;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_resp_run;
    logic               w_resp_flush;
    logic               w_push;
    logic               w_out_valid;
    logic               w_pop;
    fetch_entry_t       w_lo;
    fetch_entry_t       w_hi;
    fetch_entry_t       w_head;
    logic               w_unused;

    assign w_unused = ^{entry_pc[1:0], bus.redirect_pc[1:0]};

    // Reserve room for both halves of every in-flight response plus the new one.
    assign w_free       = DEPTH - 32'(w_count);
    assign w_need       = (32'(r_outst) + 32'd1) << 1;
    assign w_req_valid  = (r_state == RUN) && (w_free >= w_need) && (32'(r_outst) < MAX_OUTST);
    assign w_req_fire   = w_req_valid && bus.req_ready;
    assign w_resp_run   = bus.resp_valid && (r_state == RUN) && (r_outst != '0);
    assign w_resp_flush = bus.resp_valid && (r_state == FLUSH) && (r_drop != '0);
    assign w_push       = w_resp_run && !bus.redirect_valid;
    assign w_out_valid  = (r_state == RUN) && (w_count != '0) && !bus.redirect_valid;
    assign w_pop        = w_out_valid && bus.out_ready;

    // Everything still owed by memory after this cycle becomes stale on redirect.
    assign w_drop_next = OUT_W'(32'(r_drop) + 32'(r_outst) + 32'(w_req_fire)
                               - 32'(w_resp_run || w_resp_flush));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     w_state_next = RUN;
            FLUSH: begin
                if ((r_drop == '0) || (w_resp_flush && (r_drop == OUT_W'(1)))) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = BOOT;
        endcase
        if (bus.redirect_valid) begin
            w_state_next = (w_drop_next != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= '0;
            r_resp_pc  <= '0;
            r_skip_lo  <= 1'b0;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[63:3], 3'b000};
            r_resp_pc  <= {bus.redirect_pc[63:3], 3'b000};
            r_skip_lo  <= bus.redirect_pc[2];
            r_outst    <= '0;
            r_drop     <= w_drop_next;
        end else begin
            if (r_state == BOOT) begin
                r_fetch_pc <= {entry_pc[63:3], 3'b000};
                r_resp_pc  <= {entry_pc[63:3], 3'b000};
                r_skip_lo  <= entry_pc[2];
            end
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'(FETCH_BYTES);
            end
            r_outst <= OUT_W'(32'(r_outst) + 32'(w_req_fire) - 32'(w_resp_run));
            if (w_resp_flush) begin
                r_drop <= r_drop - OUT_W'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 64'(FETCH_BYTES);
                r_skip_lo <= 1'b0;
            end
        end
    end

    always_comb begin
        w_lo      = '0;
        w_hi      = '0;
        w_lo.inst = bus.resp_data[31:0];
        w_lo.pc   = r_resp_pc;
        w_hi.inst = bus.resp_data[63:32];
        w_hi.pc   = r_resp_pc + 64'(INST_BYTES);
`ifdef FETCHQ_ILLEGAL_CHECK_EN
        w_lo.illegal = is_illegal(bus.resp_data[31:0]);
        w_hi.illegal = is_illegal(bus.resp_data[63:32]);
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_flush      (bus.redirect_valid),
        .i_push0      (w_push),
        .i_push0_data (r_skip_lo ? w_hi : w_lo),
        .i_push1      (w_push && !r_skip_lo),
        .i_push1_data (w_hi),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign bus.req_valid = w_req_valid;
    assign bus.req_addr  = r_fetch_pc;
    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = w_head.inst;
    assign bus.out_pc    = w_head.pc;
`ifdef FETCHQ_ILLEGAL_CHECK_EN
    assign bus.out_illegal = w_head.illegal;
`endif

endmodule

`default_nettype wire
